// File: rtl/cs_accumulator.sv
// cs_accumulator: resolves 3:2 compressor sum/carry beats to binary
// (popcount(sum) + 2*popcount(carry)) and accumulates them over a
// programmable coherent length. One saturated result is presented per
// dump on a valid/ready handshake.
//
// Optional build macro CS_ACC_PEAK_EN adds peak_value/peak_index outputs
// tracking the largest single beat in the dump and its first index.
module cs_accumulator #(
    parameter int unsigned NUM_LANES     = 8,
    parameter int unsigned ACC_WIDTH     = 16,
    parameter int unsigned COH_LEN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     start,
    input  logic                     clear,
    input  logic [COH_LEN_WIDTH-1:0] coh_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_LANES-1:0]     sum_bits,
    input  logic [NUM_LANES-1:0]     carry_bits,
    output logic                     acc_valid,
    input  logic                     acc_ready,
    output logic [ACC_WIDTH-1:0]     acc_value,
    output logic                     acc_sat,
    output logic                     busy
`ifdef CS_ACC_PEAK_EN
    ,
    output logic [$clog2(3*NUM_LANES+1)-1:0] peak_value,
    output logic [COH_LEN_WIDTH-1:0]         peak_index
`endif
);

    // Width needed to hold one beat value (0 .. 3*NUM_LANES)
    localparam int unsigned BEAT_WIDTH = $clog2(3*NUM_LANES+1);
    localparam int unsigned ACC_SUM_W  = ACC_WIDTH + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DUMP  = 2'd2;

    logic [1:0]               state;
    logic [COH_LEN_WIDTH-1:0] coh_len_q;
    logic [COH_LEN_WIDTH-1:0] beat_cnt;

    logic [BEAT_WIDTH-1:0]    sum_cnt;
    logic [BEAT_WIDTH-1:0]    carry_cnt;
    logic [BEAT_WIDTH-1:0]    beat_value;
    logic [ACC_SUM_W-1:0]     acc_sum;
    logic [ACC_WIDTH-1:0]     acc_next;
    logic                     acc_ovf;

    logic                     start_go;
    logic                     accept;
    logic                     last_beat;

    // Handshake and status outputs are pure state decodes
    assign in_ready  = (state == S_ACCUM);
    assign acc_valid = (state == S_DUMP);
    assign busy      = (state != S_IDLE);

    // A start is only honoured from IDLE, and clear always takes priority
    assign start_go  = (state == S_IDLE) && start && !clear;
    assign accept    = in_valid && in_ready && !clear;

    // Length 0 encodes 2^COH_LEN_WIDTH: comparing against len-1 modulo the
    // counter width makes the final index 2^COH_LEN_WIDTH-1 in that case
    assign last_beat = (beat_cnt == (coh_len_q - COH_LEN_WIDTH'(1)));

    // Resolve the compressor outputs: each sum bit weighs 1, each carry bit 2
    always_comb begin
        sum_cnt   = '0;
        carry_cnt = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            sum_cnt   = sum_cnt   + BEAT_WIDTH'(sum_bits[i]);
            carry_cnt = carry_cnt + BEAT_WIDTH'(carry_bits[i]);
        end
        beat_value = sum_cnt + (carry_cnt << 1);
    end

    // Unsigned add with one guard bit; clamp to all-ones on overflow
    always_comb begin
        acc_sum  = {1'b0, acc_value} + ACC_SUM_W'(beat_value);
        acc_ovf  = acc_sum[ACC_WIDTH];
        acc_next = acc_ovf ? '1 : acc_sum[ACC_WIDTH-1:0];
    end

    // Control FSM: IDLE -> ACCUM -> DUMP -> IDLE, clear aborts from anywhere
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept && last_beat) begin
                        state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (acc_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Coherent length latch and beat counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            coh_len_q <= '0;
            beat_cnt  <= '0;
        end else if (start_go) begin
            coh_len_q <= coh_len;
            beat_cnt  <= '0;
        end else if (accept) begin
            beat_cnt  <= beat_cnt + COH_LEN_WIDTH'(1);
        end
    end

    // Accumulator doubles as the result register; it is left untouched by
    // clear and by the DUMP handshake so the last result stays visible
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_value <= '0;
            acc_sat   <= 1'b0;
        end else if (start_go) begin
            acc_value <= '0;
            acc_sat   <= 1'b0;
        end else if (accept) begin
            acc_value <= acc_next;
            if (acc_ovf) begin
                acc_sat <= 1'b1;
            end
        end
    end

`ifdef CS_ACC_PEAK_EN
    // Peak tracker: strict greater-than so ties keep the earliest index
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            peak_value <= '0;
            peak_index <= '0;
        end else if (start_go) begin
            peak_value <= '0;
            peak_index <= '0;
        end else if (accept && (beat_value > peak_value)) begin
            peak_value <= beat_value;
            peak_index <= beat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_cs_accumulator.sv
// Bench for cs_accumulator: a 16-bit instance and an 8-bit instance share
// one stimulus stream; a bench-side model pushes expected dump results to a
// queue which each scenario pops and compares when acc_valid appears.
module tb_cs_accumulator;

    logic        clk = 1'b0;
    logic        rst_b, start, clear, in_valid, acc_ready;
    logic [7:0]  coh_len, sum_bits, carry_bits;

    logic        in_ready_a, acc_valid_a, acc_sat_a, busy_a;
    logic [15:0] acc_value_a;
    logic        in_ready_b, acc_valid_b, acc_sat_b, busy_b;
    logic [7:0]  acc_value_b;
`ifdef CS_ACC_PEAK_EN
    logic [4:0]  peak_value_a, peak_value_b;
    logic [7:0]  peak_index_a, peak_index_b;
`endif

    int checks = 0;
    int passed = 0;

    typedef struct {
        int unsigned a_val;
        bit          a_sat;
        int unsigned b_val;
        bit          b_sat;
        int unsigned pk_v;
        int unsigned pk_i;
    } exp_t;

    exp_t        sb[$];
    int unsigned m_tot, m_peak, m_pidx, m_idx;

    always #5 clk = ~clk;

    cs_accumulator #(.NUM_LANES(8), .ACC_WIDTH(16), .COH_LEN_WIDTH(8)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(start), .clear(clear), .coh_len(coh_len),
        .in_valid(in_valid), .in_ready(in_ready_a), .sum_bits(sum_bits),
        .carry_bits(carry_bits), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
        .acc_value(acc_value_a), .acc_sat(acc_sat_a),
`ifdef CS_ACC_PEAK_EN
        .peak_value(peak_value_a), .peak_index(peak_index_a),
`endif
        .busy(busy_a)
    );

    cs_accumulator #(.NUM_LANES(8), .ACC_WIDTH(8), .COH_LEN_WIDTH(8)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start), .clear(clear), .coh_len(coh_len),
        .in_valid(in_valid), .in_ready(in_ready_b), .sum_bits(sum_bits),
        .carry_bits(carry_bits), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
        .acc_value(acc_value_b), .acc_sat(acc_sat_b),
`ifdef CS_ACC_PEAK_EN
        .peak_value(peak_value_b), .peak_index(peak_index_b),
`endif
        .busy(busy_b)
    );

    function automatic int unsigned beat_val(input logic [7:0] s, input logic [7:0] c);
        return $countones(s) + 2 * $countones(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_dump(input logic [7:0] len);
        coh_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        coh_len = 8'($urandom);
        m_tot = 0; m_peak = 0; m_pidx = 0; m_idx = 0;
    endtask

    task automatic drive_beat(input logic [7:0] s, input logic [7:0] c, input int gap);
        int unsigned v;
        v = beat_val(s, c);
        in_valid   = 1'b1;
        sum_bits   = s;
        carry_bits = c;
        if (v > m_peak) begin
            m_peak = v;
            m_pidx = m_idx;
        end
        m_tot += v;
        m_idx++;
        tick();
        in_valid   = 1'b0;
        sum_bits   = 8'($urandom);
        carry_bits = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic push_expect;
        exp_t e;
        e.a_val = (m_tot > 65535) ? 65535 : m_tot;
        e.a_sat = (m_tot > 65535);
        e.b_val = (m_tot > 255) ? 255 : m_tot;
        e.b_sat = (m_tot > 255);
        e.pk_v  = m_peak;
        e.pk_i  = m_pidx;
        sb.push_back(e);
    endtask

    task automatic handshake;
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_b = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; acc_ready = 1'b0;
        coh_len = '0; sum_bits = '0; carry_bits = '0;
        #12;
        checks++; if ({in_ready_a, acc_valid_a, acc_sat_a, busy_a, acc_value_a} !== 20'd0)
            $display("FAIL reset_a: got rdy=%b vld=%b sat=%b busy=%b val=%0d required all 0", in_ready_a, acc_valid_a, acc_sat_a, busy_a, acc_value_a); else passed++;
        checks++; if ({in_ready_b, acc_valid_b, acc_sat_b, busy_b, acc_value_b} !== 12'd0)
            $display("FAIL reset_b: got rdy=%b vld=%b sat=%b busy=%b val=%0d required all 0", in_ready_b, acc_valid_b, acc_sat_b, busy_b, acc_value_b); else passed++;
        repeat (2) tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        exp_t e;
        begin_dump(8'd4);
        checks++; if ({in_ready_a, busy_a, acc_value_a} !== {2'b11, 16'd0})
            $display("FAIL basic_entry: got rdy=%b busy=%b val=%0d required 1 1 0", in_ready_a, busy_a, acc_value_a); else passed++;
        for (int i = 0; i < 3; i++) drive_beat(8'hFF, 8'h00, 0);
        checks++; if (acc_valid_a !== 1'b0)
            $display("FAIL basic_early_valid: got %b required 0", acc_valid_a); else passed++;
        drive_beat(8'hFF, 8'h00, 0);
        push_expect();
        checks++; if (acc_valid_a !== 1'b1)
            $display("FAIL basic_latency: acc_valid=%b required 1", acc_valid_a); else passed++;
        e = sb.pop_front();
        checks++; if ({acc_value_a, acc_sat_a} !== {e.a_val[15:0], e.a_sat})
            $display("FAIL basic_a: got %0d/%b required %0d/%b", acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
        checks++; if ({acc_value_b, acc_sat_b} !== {e.b_val[7:0], e.b_sat})
            $display("FAIL basic_b: got %0d/%b required %0d/%b", acc_value_b, acc_sat_b, e.b_val, e.b_sat); else passed++;
        handshake();
        checks++; if ({acc_valid_a, busy_a, in_ready_a, acc_value_a} !== {3'b000, e.a_val[15:0]})
            $display("FAIL basic_idle: got vld=%b busy=%b rdy=%b val=%0d required 0 0 0 %0d", acc_valid_a, busy_a, in_ready_a, acc_value_a, e.a_val); else passed++;
    endtask

    task automatic test_wrap;
        exp_t e;
        begin_dump(8'd0);
        for (int i = 0; i < 255; i++) drive_beat(8'hFF, 8'hFF, 0);
        checks++; if ({acc_valid_a, in_ready_a} !== 2'b01)
            $display("FAIL wrap_before_last: got vld=%b rdy=%b required 0 1", acc_valid_a, in_ready_a); else passed++;
        drive_beat(8'hFF, 8'hFF, 0);
        push_expect();
        checks++; if (acc_valid_a !== 1'b1)
            $display("FAIL wrap_latency: acc_valid=%b required 1", acc_valid_a); else passed++;
        e = sb.pop_front();
        checks++; if ({acc_value_a, acc_sat_a} !== {e.a_val[15:0], e.a_sat})
            $display("FAIL wrap_a: got %0d/%b required %0d/%b", acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
        checks++; if ({acc_value_b, acc_sat_b} !== {e.b_val[7:0], e.b_sat})
            $display("FAIL wrap_b: got %0d/%b required %0d/%b", acc_value_b, acc_sat_b, e.b_val, e.b_sat); else passed++;
        handshake();
    endtask

    task automatic test_saturate;
        exp_t e;
        begin_dump(8'd11);
        for (int i = 0; i < 11; i++) drive_beat(8'hFF, 8'hFF, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_b, acc_value_b, acc_sat_b} !== {1'b1, e.b_val[7:0], e.b_sat})
            $display("FAIL sat_b: got vld=%b %0d/%b required 1 %0d/%b", acc_valid_b, acc_value_b, acc_sat_b, e.b_val, e.b_sat); else passed++;
        checks++; if ({acc_value_a, acc_sat_a} !== {e.a_val[15:0], e.a_sat})
            $display("FAIL sat_a: got %0d/%b required %0d/%b", acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
        handshake();
        begin_dump(8'd1);
        checks++; if ({acc_value_b, acc_sat_b} !== 9'd0)
            $display("FAIL sat_cleared_on_start: got %0d/%b required 0/0", acc_value_b, acc_sat_b); else passed++;
        drive_beat(8'h01, 8'h00, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_b, acc_value_b, acc_sat_b} !== {1'b1, e.b_val[7:0], e.b_sat})
            $display("FAIL sat_next_b: got vld=%b %0d/%b required 1 %0d/%b", acc_valid_b, acc_value_b, acc_sat_b, e.b_val, e.b_sat); else passed++;
        handshake();
    endtask

    task automatic test_gaps_backpressure;
        exp_t e;
        begin_dump(8'd3);
        drive_beat(8'h0F, 8'h01, 2);
        drive_beat(8'h0F, 8'h01, 2);
        drive_beat(8'h0F, 8'h01, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_a, acc_value_a, acc_sat_a} !== {1'b1, e.a_val[15:0], e.a_sat})
            $display("FAIL gaps_a: got vld=%b %0d/%b required 1 %0d/%b", acc_valid_a, acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
`ifdef CS_ACC_PEAK_EN
        checks++; if ({peak_value_a, peak_index_a} !== {e.pk_v[4:0], e.pk_i[7:0]})
            $display("FAIL gaps_peak: got %0d@%0d required %0d@%0d", peak_value_a, peak_index_a, e.pk_v, e.pk_i); else passed++;
`endif
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            tick();
            checks++; if ({acc_valid_a, in_ready_a, busy_a, acc_value_a, acc_sat_a} !== {3'b101, e.a_val[15:0], e.a_sat})
                $display("FAIL hold_%0d: got vld=%b rdy=%b busy=%b %0d/%b required 1 0 1 %0d/%b", i, acc_valid_a, in_ready_a, busy_a, acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
        end
        in_valid = 1'b0;
        handshake();
        checks++; if ({acc_valid_a, busy_a} !== 2'b00)
            $display("FAIL gaps_idle: got vld=%b busy=%b required 0 0", acc_valid_a, busy_a); else passed++;
    endtask

    task automatic test_clear;
        exp_t e;
        begin_dump(8'd4);
        drive_beat(8'h01, 8'h01, 0);
        drive_beat(8'h01, 8'h01, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if ({acc_valid_a, in_ready_a, busy_a, acc_value_a} !== {3'b000, 16'd6})
            $display("FAIL clear_abort: got vld=%b rdy=%b busy=%b val=%0d required 0 0 0 6", acc_valid_a, in_ready_a, busy_a, acc_value_a); else passed++;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++; if ({acc_valid_a, busy_a, acc_value_a} !== {2'b00, 16'd6})
            $display("FAIL clear_stays_idle: got vld=%b busy=%b val=%0d required 0 0 6", acc_valid_a, busy_a, acc_value_a); else passed++;
        coh_len = 8'd4; start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        checks++; if (busy_a !== 1'b0)
            $display("FAIL clear_beats_start: got busy=%b required 0", busy_a); else passed++;
        begin_dump(8'd4);
        for (int i = 0; i < 4; i++) drive_beat(8'h01, 8'h01, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_a, acc_value_a, acc_sat_a} !== {1'b1, e.a_val[15:0], e.a_sat})
            $display("FAIL clear_restart: got vld=%b %0d/%b required 1 %0d/%b", acc_valid_a, acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
        handshake();
    endtask

    task automatic test_start_ignored;
        exp_t e;
        begin_dump(8'd2);
        drive_beat(8'h07, 8'h00, 0);
        coh_len = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        drive_beat(8'h00, 8'h03, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_a, acc_value_a} !== {1'b1, e.a_val[15:0]})
            $display("FAIL start_in_accum: got vld=%b val=%0d required 1 %0d", acc_valid_a, acc_value_a, e.a_val); else passed++;
        coh_len = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if ({acc_valid_a, in_ready_a, busy_a, acc_value_a} !== {3'b101, e.a_val[15:0]})
            $display("FAIL start_in_dump: got vld=%b rdy=%b busy=%b val=%0d required 1 0 1 %0d", acc_valid_a, in_ready_a, busy_a, acc_value_a, e.a_val); else passed++;
        handshake();
    endtask

    task automatic test_reset_mid;
        begin_dump(8'd4);
        drive_beat(8'hFF, 8'h00, 0);
        drive_beat(8'hFF, 8'h00, 0);
        #2 rst_b = 1'b0;
        #1;
        checks++; if ({in_ready_a, acc_valid_a, acc_sat_a, busy_a, acc_value_a} !== 20'd0)
            $display("FAIL reset_mid_async: got rdy=%b vld=%b sat=%b busy=%b val=%0d required all 0", in_ready_a, acc_valid_a, acc_sat_a, busy_a, acc_value_a); else passed++;
        tick();
        rst_b = 1'b1;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        checks++; if ({acc_valid_a, busy_a, acc_value_a} !== 18'd0)
            $display("FAIL reset_mid_no_result: got vld=%b busy=%b val=%0d required 0 0 0", acc_valid_a, busy_a, acc_value_a); else passed++;
    endtask

    task automatic test_peak;
        exp_t e;
        begin_dump(8'd5);
        drive_beat(8'h07, 8'h00, 0);
        drive_beat(8'hFF, 8'h01, 1);
        drive_beat(8'h1F, 8'h01, 0);
        drive_beat(8'h3F, 8'h03, 0);
        drive_beat(8'h00, 8'h01, 0);
        push_expect();
        e = sb.pop_front();
        checks++; if ({acc_valid_a, acc_value_a} !== {1'b1, e.a_val[15:0]})
            $display("FAIL peak_sum: got vld=%b val=%0d required 1 %0d", acc_valid_a, acc_value_a, e.a_val); else passed++;
`ifdef CS_ACC_PEAK_EN
        checks++; if ({peak_value_a, peak_index_a} !== {e.pk_v[4:0], e.pk_i[7:0]})
            $display("FAIL peak_tie: got %0d@%0d required %0d@%0d", peak_value_a, peak_index_a, e.pk_v, e.pk_i); else passed++;
`endif
        handshake();
    endtask

    task automatic test_random;
        exp_t e;
        int unsigned len;
        for (int d = 0; d < 6; d++) begin
            len = $urandom_range(1, 6);
            begin_dump(8'(len));
            for (int unsigned b = 0; b < len; b++)
                drive_beat(8'($urandom), 8'($urandom), (b == len - 1) ? 0 : int'($urandom_range(0, 2)));
            push_expect();
            e = sb.pop_front();
            checks++; if ({acc_valid_a, acc_value_a, acc_sat_a} !== {1'b1, e.a_val[15:0], e.a_sat})
                $display("FAIL rand_%0d_a: got vld=%b %0d/%b required 1 %0d/%b", d, acc_valid_a, acc_value_a, acc_sat_a, e.a_val, e.a_sat); else passed++;
            checks++; if ({acc_value_b, acc_sat_b} !== {e.b_val[7:0], e.b_sat})
                $display("FAIL rand_%0d_b: got %0d/%b required %0d/%b", d, acc_value_b, acc_sat_b, e.b_val, e.b_sat); else passed++;
`ifdef CS_ACC_PEAK_EN
            checks++; if ({peak_value_a, peak_index_a} !== {e.pk_v[4:0], e.pk_i[7:0]})
                $display("FAIL rand_%0d_peak: got %0d@%0d required %0d@%0d", d, peak_value_a, peak_index_a, e.pk_v, e.pk_i); else passed++;
`endif
            repeat ($urandom_range(0, 3)) tick();
            handshake();
            checks++; if ({acc_valid_a, busy_a} !== 2'b00)
                $display("FAIL rand_%0d_idle: got vld=%b busy=%b required 0 0", d, acc_valid_a, busy_a); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_saturate();
        test_gaps_backpressure();
        test_clear();
        test_start_ignored();
        test_reset_mid();
        test_peak();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
